mousetrap_inject_arbiter: RTL and testbench

Clocked arbiter and sequencer that shares the input channel of a MouseTrap asynchronous pipeline between NUM_REQ synchronous requesters. It grants one requester at a time by round-robin and latches that requester's word. It holds the word stable for a programmed bundling-delay setup window, then issues a two-phase (transition-signalled) request. It waits for the pipeline's acknowledge transition, brought in through a synchronizer, before granting again. It sits at the clocked/asynchronous boundary, in front of the first pipeline stage.

---
 rtl/mousetrap_pkg.sv | 27 ++
 rtl/rr_arbiter.sv | 37 +++
 rtl/mousetrap_inject_arbiter.sv | 116 +++++++++++
 tb/tb_mousetrap_inject_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mousetrap_pkg.sv
// Shared definitions for the MouseTrap injection arbiter.
//   - state encodings for the inject FSM
//   - clog2 helper for index/counter widths
//   - default data word width
package mousetrap_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SETUP = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  localparam int unsigned DEFAULT_WORD_WIDTH = 32;

  typedef enum logic [1:0] {
    StIdle  = IDLE,
    StSetup = SETUP,
    StWait  = WAIT
  } state_e;

  // Number of bits needed to hold values 0..n-1 (0 for n <= 1).
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req : request vector
//   ptr : index of the last winner; search starts at ptr+1 and wraps
//   gnt : one-hot grant (all zero when no request)
//   idx : encoded index of the granted requester
module rr_arbiter
  import mousetrap_pkg::*;
#(
  parameter int unsigned N = 4,
  localparam int unsigned IW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic          found;
  logic [IW-1:0] cand;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    // Visit ptr+1, ptr+2, ..., ptr (mod N); first hit wins.
    for (int unsigned i = 1; i <= N; i++) begin
      cand = IW'((32'(ptr) + i) % N);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/mousetrap_inject_arbiter.sv
// Shares the input channel of a MouseTrap pipeline between NUM_REQ clocked requesters.
// A round-robin winner's word is latched, held for SETUP_CYCLES edges (bundling delay),
// then announced with a two-phase request. The next grant waits for the matching
// acknowledge phase, brought in through a SYNC_STAGES flop chain.
//   clk, reset        : clock, synchronous active-high reset
//   in_valid/in_data  : per-requester word offers (requester i at [i*WORD_WIDTH +: WORD_WIDTH])
//   in_ready          : one-hot grant, only while idle
//   chan_req/chan_data: two-phase request and bundled data, straight from flops
//   chan_ack          : two-phase acknowledge, asynchronous
//   grant_id          : last granted requester
//   busy              : FSM not idle
//   timeout_err       : sticky, set after TIMEOUT unacknowledged wait cycles
module mousetrap_inject_arbiter
  import mousetrap_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned WORD_WIDTH   = DEFAULT_WORD_WIDTH,
  parameter int unsigned SETUP_CYCLES = 2,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned TIMEOUT      = 255,
  localparam int unsigned IdW = clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            in_valid,
  input  logic [NUM_REQ*WORD_WIDTH-1:0] in_data,
  output logic [NUM_REQ-1:0]            in_ready,
  output logic                          chan_req,
  output logic [WORD_WIDTH-1:0]         chan_data,
  input  logic                          chan_ack,
  output logic [IdW-1:0]                grant_id,
  output logic                          busy,
  output logic                          timeout_err
);

  localparam int unsigned CntW = clog2(SETUP_CYCLES + 1);
  localparam int unsigned TW   = clog2(TIMEOUT + 1);

  state_e                 state_q;
  logic [IdW-1:0]         ptr_q;
  logic [CntW-1:0]        cnt_q;
  logic [TW-1:0]          tcnt_q;
  logic [SYNC_STAGES-1:0] ack_sync_q;
  logic                   ack_s;

  logic [NUM_REQ-1:0]     win_gnt;
  logic [IdW-1:0]         win_idx;
  logic [WORD_WIDTH-1:0]  win_word;

  rr_arbiter #(
    .N(NUM_REQ)
  ) u_rr (
    .req(in_valid),
    .ptr(ptr_q),
    .gnt(win_gnt),
    .idx(win_idx)
  );

  // One-hot AND-OR select of the winner's word.
  always_comb begin
    win_word = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_gnt[i]) win_word = win_word | in_data[i*WORD_WIDTH +: WORD_WIDTH];
    end
  end

  assign ack_s    = ack_sync_q[SYNC_STAGES-1];
  assign in_ready = (state_q == StIdle) ? win_gnt : '0;
  assign busy     = (state_q != StIdle);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      chan_req    <= 1'b0;
      chan_data   <= '0;
      grant_id    <= '0;
      ptr_q       <= IdW'(NUM_REQ - 1);
      cnt_q       <= '0;
      tcnt_q      <= '0;
      timeout_err <= 1'b0;
      ack_sync_q  <= '0;
    end else begin
      ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], chan_ack};
      case (state_q)
        StIdle: begin
          if (|in_valid) begin
            chan_data <= win_word;
            grant_id  <= win_idx;
            ptr_q     <= win_idx;
            cnt_q     <= '0;
            state_q   <= StSetup;
          end
        end
        StSetup: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CntW'(SETUP_CYCLES - 1)) begin
            chan_req <= ~chan_req;
            tcnt_q   <= '0;
            state_q  <= StWait;
          end
        end
        StWait: begin
          if (ack_s == chan_req) begin
            state_q <= StIdle;
          end else if (tcnt_q != TW'(TIMEOUT)) begin
            // Keep waiting forever; the token is never re-issued or dropped.
            tcnt_q <= tcnt_q + 1'b1;
            if (tcnt_q == TW'(TIMEOUT - 1)) timeout_err <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mousetrap_inject_arbiter.sv
module tb_mousetrap_inject_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   in_valid, in_valid2;
  logic [127:0] in_data, in_data2;
  logic [3:0]   in_ready, in_ready2;
  logic         chan_req, chan_req2;
  logic [31:0]  chan_data, chan_data2;
  logic         ack1 = 1'b0;
  logic         ack2 = 1'b0;
  logic [1:0]   grant_id, grant_id2;
  logic         busy, busy2;
  logic         timeout_err, timeout_err2;
  logic         hold;

  logic [31:0]  word [4];
  logic [31:0]  word2 [4];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int viol1 = 0;
  int viol2 = 0;
  int rx2 = 0;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] data;
    int          edge_n;
  } exp_t;
  exp_t        exp_q[$];
  logic [31:0] exp2[$];
  logic [31:0] pipe2[$];

  // Test vectors: reset first?, valid mask, token count, expected grant ids (2 bits each, LSB first)
  typedef struct packed {
    logic        rst;
    logic [3:0]  mask;
    int          n;
    logic [15:0] ids;
  } vec_t;
  vec_t vecs [4];

  always #5 clk = ~clk;

  always_comb begin
    in_data = '0;
    for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = word[i];
  end

  always_comb begin
    in_data2 = '0;
    for (int i = 0; i < 4; i++) in_data2[i*32 +: 32] = word2[i];
  end

  mousetrap_inject_arbiter dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .chan_req(chan_req), .chan_data(chan_data), .chan_ack(ack1), .grant_id(grant_id),
    .busy(busy), .timeout_err(timeout_err)
  );

  mousetrap_inject_arbiter #(
    .SETUP_CYCLES(1),
    .SYNC_STAGES(3)
  ) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid2), .in_data(in_data2), .in_ready(in_ready2),
    .chan_req(chan_req2), .chan_data(chan_data2), .chan_ack(ack2), .grant_id(grant_id2),
    .busy(busy2), .timeout_err(timeout_err2)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Pipeline model for dut: acks one cycle after seeing the new request phase.
  initial begin
    int acnt;
    acnt = 0;
    forever begin
      @(posedge clk);
      if (reset) begin
        ack1 <= 1'b0;
        acnt = 0;
      end else if (!hold && ack1 != chan_req) begin
        if (acnt == 1) begin
          ack1 <= chan_req;
          acnt = 0;
        end else begin
          acnt++;
        end
      end
    end
  end

  // Scoreboard for dut: each request toggle pops the token expected at grant time.
  initial begin
    logic        prev_req, prev_busy;
    logic [31:0] prev_data;
    exp_t        e;
    prev_req = 1'b0; prev_busy = 1'b0; prev_data = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (chan_req != prev_req) begin
          if (exp_q.size() == 0) begin
            check("unexpected_req_toggle", 64'(chan_req), 64'(prev_req));
          end else begin
            e = exp_q.pop_front();
            check("grant_id", 64'(grant_id), 64'(e.id));
            check("chan_data", 64'(chan_data), 64'(e.data));
            check("setup_edges", 64'(cyc - e.edge_n), 64'(2));
          end
        end
        if (chan_data != prev_data && prev_busy) viol1++;
      end
      prev_req  = chan_req;
      prev_busy = busy;
      prev_data = chan_data;
    end
  end

  // 4-stage MouseTrap model for dut2: ~3 ns latch+ack, slow sink drains every 12 cycles.
  initial forever begin
    @(chan_req2);
    if (!reset) begin
      while (pipe2.size() >= 4) @(posedge clk);
      #3;
      pipe2.push_back(chan_data2);
      ack2 = chan_req2;
    end
  end

  initial begin
    int          dcnt;
    logic [31:0] d;
    dcnt = 0;
    forever begin
      @(posedge clk);
      dcnt++;
      if (dcnt >= 12) begin
        dcnt = 0;
        if (pipe2.size() > 0) begin
          d = pipe2.pop_front();
          rx2++;
          if (exp2.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL pipe_extra: got 0x%0h, required no token", d);
          end else begin
            check("pipe_data", 64'(d), 64'(exp2.pop_front()));
          end
        end
      end
    end
  end

  initial begin
    logic        p_busy2;
    logic [31:0] p_data2;
    p_busy2 = 1'b0; p_data2 = '0;
    forever begin
      @(negedge clk);
      if (!reset && chan_data2 != p_data2 && p_busy2) viol2++;
      p_busy2 = busy2;
      p_data2 = chan_data2;
    end
  end

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(busy), 64'(0));
  endtask

  task automatic grant_one(input logic [3:0] mask, input logic [1:0] id);
    exp_t e;
    wait_idle(60, "idle_before_grant");
    in_valid = mask;
    #1;
    check("in_ready", 64'(in_ready), 64'(4'b0001 << id));
    e.id = id;
    e.data = word[id];
    e.edge_n = cyc + 1;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    word[id] = word[id] + 32'h0001_0001;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    in_valid = '0;
    hold = 1'b0;
    word[0] = 32'hDEAD_BEEF;
    word[1] = 32'h1100_0000;
    word[2] = 32'h2200_0000;
    word[3] = 32'h3300_0000;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1; hold = 1'b0; in_valid = '0; in_valid2 = '0;
    for (int i = 0; i < 4; i++) begin
      word[i]  = '0;
      word2[i] = 32'hC0DE_0000 + 32'(i) * 32'h100;
    end

    vecs[0] = '{rst: 1'b1, mask: 4'b0001, n: 2, ids: 16'h0000}; // 0,0
    vecs[1] = '{rst: 1'b1, mask: 4'b1111, n: 8, ids: 16'hE4E4}; // 0,1,2,3,0,1,2,3
    vecs[2] = '{rst: 1'b1, mask: 4'b0010, n: 1, ids: 16'h0001}; // 1 (ptr becomes 1)
    vecs[3] = '{rst: 1'b0, mask: 4'b1010, n: 2, ids: 16'h0007}; // 3 then 1

    for (int i = 0; i < 4; i++) begin
      if (vecs[i].rst) begin
        do_reset();
        check("rst_chan_req", 64'(chan_req), 64'(0));
        check("rst_chan_data", 64'(chan_data), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(0));
        check("rst_grant_id", 64'(grant_id), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_timeout_err", 64'(timeout_err), 64'(0));
      end
      for (int t = 0; t < vecs[i].n; t++) grant_one(vecs[i].mask, vecs[i].ids[2*t +: 2]);
      in_valid = '0;
      wait_idle(60, "seq_done");
      if (i == 0) check("req_phase_back_to_0", 64'(chan_req), 64'(0));
    end

    // Stalled acknowledge: timeout flags but the token stays put.
    do_reset();
    hold = 1'b1;
    grant_one(4'b0001, 2'd0);
    in_valid = '0;
    repeat (200) @(negedge clk);
    check("no_timeout_yet", 64'(timeout_err), 64'(0));
    check("req_stable_200", 64'(chan_req), 64'(1));
    repeat (100) @(negedge clk);
    check("timeout_set", 64'(timeout_err), 64'(1));
    check("req_stable_300", 64'(chan_req), 64'(1));
    check("busy_in_wait", 64'(busy), 64'(1));
    hold = 1'b0;
    wait_idle(20, "late_ack_idle");
    check("timeout_sticky", 64'(timeout_err), 64'(1));

    // Reset while waiting with chan_req=1.
    grant_one(4'b0001, 2'd0);
    in_valid = '0;
    wait_idle(60, "second_token_idle");
    check("req_phase_0", 64'(chan_req), 64'(0));
    hold = 1'b1;
    grant_one(4'b0001, 2'd0);
    in_valid = '0;
    repeat (10) @(negedge clk);
    check("wait_req_1", 64'(chan_req), 64'(1));
    check("wait_busy", 64'(busy), 64'(1));
    reset = 1'b1;
    @(negedge clk);
    check("midrst_chan_req", 64'(chan_req), 64'(0));
    check("midrst_chan_data", 64'(chan_data), 64'(0));
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_timeout_err", 64'(timeout_err), 64'(0));
    check("midrst_grant_id", 64'(grant_id), 64'(0));
    reset = 1'b0;
    hold = 1'b0;
    exp_q.delete();
    grant_one(4'b1111, 2'd0);
    in_valid = '0;
    wait_idle(60, "after_midrst_idle");

    // dut2: SETUP_CYCLES=1, SYNC_STAGES=3, 20 tokens through a 4-stage pipeline.
    for (int g = 0; g < 20; g++) begin
      n = 0;
      @(negedge clk);
      while (busy2 && n < 200) begin
        @(negedge clk);
        n++;
      end
      check("dut2_idle", 64'(busy2), 64'(0));
      in_valid2 = 4'hF;
      #1;
      check("dut2_in_ready", 64'(in_ready2), 64'(4'b0001 << (g % 4)));
      exp2.push_back(word2[g % 4]);
      @(posedge clk);
      #1;
      word2[g % 4] = word2[g % 4] + 32'h10;
    end
    in_valid2 = '0;
    n = 0;
    while (rx2 < 20 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    check("dut2_rx_count", 64'(rx2), 64'(20));

    @(negedge clk);
    check("dut_queue_empty", 64'(exp_q.size()), 64'(0));
    check("dut2_queue_empty", 64'(exp2.size()), 64'(0));
    check("dut_data_held_outside_idle", 64'(viol1), 64'(0));
    check("dut2_data_held_outside_idle", 64'(viol2), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
